imem_port_arbiter: RTL and testbench

- Shares the single port of the byte-addressed instruction memory between two requesters: the CPU fetch stage (word reads) and the program loader (word writes during boot or debug).
- Sits between the fetch unit, the loader and a synchronous instruction-memory macro that has fixed read latency.
- Provides round-robin arbitration, alignment and range checking, and in-order read-response tracking.

---
 rtl/imem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_imem_port_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// ---------------------------------------------------------------------------
// imem_port_arbiter
//
// Shares the single port of a synchronous, byte-addressed instruction memory
// between the CPU fetch stage (word reads) and the program loader (word
// writes). Round-robin arbitration, alignment/range checking, and in-order
// read-response tracking through a RD_LATENCY-deep tag pipeline.
//
// Handshake (both requesters): a request is accepted in the cycle its gnt is
// high; gnt is combinational from req and the arbitration state. The
// requester holds req/addr/data stable until it sees gnt and may deassert or
// change them in the following cycle. Fetch responses have no backpressure.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   f_req, f_addr            fetch read request and byte address
//   f_gnt                    fetch request accepted this cycle
//   f_rvalid, f_rdata        fetch response (little-endian word)
//   f_fault                  response is a misaligned/out-of-range fault
//   l_req, l_addr, l_wdata   loader write request, byte address, data
//   l_gnt                    loader request accepted this cycle
//   l_err                    pulse: previous accepted write was dropped
//   m_en, m_we               memory strobe and write enable
//   m_addr, m_wdata          memory word-aligned byte address, write data
//   m_rdata                  memory read data, RD_LATENCY after read strobe
//
// RD_LATENCY must be in 1..4.
// ---------------------------------------------------------------------------
module imem_port_arbiter #(
    parameter int unsigned MEMORY_SIZE = 8196,
    parameter int unsigned RD_LATENCY  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    output logic        f_fault,
    input  logic        l_req,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wdata,
    output logic        l_gnt,
    output logic        l_err,
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    localparam logic [32:0] MEM_LIMIT = 33'(MEMORY_SIZE);

    // 0: fetch was granted last, 1: loader was granted last
    logic                  last_grant;
    logic                  f_legal;
    logic                  l_legal;
    logic                  f_access;
    logic                  l_access;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    // Tag pipeline: one slot per cycle of read latency. Stage 0 is written
    // on the grant edge, so the last stage is visible RD_LATENCY cycles
    // after the grant cycle, matching the memory's read data.
    logic [RD_LATENCY-1:0] tag_valid;
    logic [RD_LATENCY-1:0] tag_fault;

    always_comb begin
        // 33-bit sum so addr+3 cannot wrap for addresses near 2^32
        f_legal = (f_addr[1:0] == 2'b00) && (({1'b0, f_addr} + 33'd3) < MEM_LIMIT);
        l_legal = (l_addr[1:0] == 2'b00) && (({1'b0, l_addr} + 33'd3) < MEM_LIMIT);

        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (!rst) begin
            if (f_req && (!l_req || last_grant)) begin
                f_gnt = 1'b1;
            end else if (l_req) begin
                l_gnt = 1'b1;
            end
        end

        f_access = f_gnt && f_legal;
        l_access = l_gnt && l_legal;

        m_en    = f_access || l_access;
        m_we    = l_access;
        // Address/data hold their last driven values when no access is made
        m_addr  = addr_q;
        m_wdata = wdata_q;
        if (f_access) begin
            m_addr = f_addr;
        end else if (l_access) begin
            m_addr  = l_addr;
            m_wdata = l_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            l_err      <= 1'b0;
            tag_valid  <= '0;
            tag_fault  <= '0;
        end else begin
            if (f_gnt) begin
                last_grant <= 1'b0;
            end else if (l_gnt) begin
                last_grant <= 1'b1;
            end

            if (m_en) begin
                addr_q <= m_addr;
            end
            if (l_access) begin
                wdata_q <= l_wdata;
            end

            l_err <= l_gnt && !l_legal;

            // Loader grants and idle cycles push an empty slot
            tag_valid[0] <= f_gnt;
            tag_fault[0] <= f_gnt && !f_legal;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_fault[i] <= tag_fault[i-1];
            end
        end
    end

    // Gated by rst so that reads in flight when reset arrives never respond
    always_comb begin
        f_rvalid = !rst && tag_valid[RD_LATENCY-1];
        f_fault  = f_rvalid && tag_fault[RD_LATENCY-1];
        f_rdata  = (f_rvalid && !tag_fault[RD_LATENCY-1]) ? m_rdata : '0;
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_port_arbiter
//
// Two instances share one set of request inputs: dut_a with RD_LATENCY=1 and
// dut_b with RD_LATENCY=3, each with its own behavioural memory macro.
// A negedge monitor models arbitration, the memory strobe, l_err and the
// expected fetch responses (pushed to a queue at grant time, popped when due).
// ---------------------------------------------------------------------------
module tb_imem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req;
    logic [31:0] f_addr;
    logic        l_req;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;

    logic        fa_gnt, fa_rvalid, fa_fault, la_gnt, la_err, ma_en, ma_we;
    logic [31:0] fa_rdata, ma_addr, ma_wdata, ma_rdata;
    logic        fb_gnt, fb_rvalid, fb_fault, lb_gnt, lb_err, mb_en, mb_we;
    logic [31:0] fb_rdata, mb_addr, mb_wdata, mb_rdata;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_port_arbiter #(.MEMORY_SIZE(8196), .RD_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(fa_gnt), .f_rvalid(fa_rvalid),
        .f_rdata(fa_rdata), .f_fault(fa_fault),
        .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(la_gnt), .l_err(la_err),
        .m_en(ma_en), .m_we(ma_we), .m_addr(ma_addr), .m_wdata(ma_wdata), .m_rdata(ma_rdata)
    );

    imem_port_arbiter #(.MEMORY_SIZE(8196), .RD_LATENCY(3)) dut_b (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(fb_gnt), .f_rvalid(fb_rvalid),
        .f_rdata(fb_rdata), .f_fault(fb_fault),
        .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(lb_gnt), .l_err(lb_err),
        .m_en(mb_en), .m_we(mb_we), .m_addr(mb_addr), .m_wdata(mb_wdata), .m_rdata(mb_rdata)
    );

    // ---------------- memory macros ----------------
    logic [31:0] mem_a [0:2048] = '{default: 32'h0};
    logic [31:0] mem_b [0:2048] = '{default: 32'h0};
    logic [31:0] rd_a = 32'h0;
    logic [31:0] rd_b [0:2] = '{default: 32'h0};

    always @(posedge clk) begin
        if (ma_en && ma_we && ma_addr[31:2] < 30'd2049) mem_a[ma_addr[13:2]] <= ma_wdata;
        rd_a <= (ma_en && !ma_we && ma_addr[31:2] < 30'd2049) ? mem_a[ma_addr[13:2]] : 32'hDEADBEEF;
    end
    assign ma_rdata = rd_a;

    always @(posedge clk) begin
        if (mb_en && mb_we && mb_addr[31:2] < 30'd2049) mem_b[mb_addr[13:2]] <= mb_wdata;
        rd_b[0] <= (mb_en && !mb_we && mb_addr[31:2] < 30'd2049) ? mem_b[mb_addr[13:2]] : 32'hDEADBEEF;
        rd_b[1] <= rd_b[0];
        rd_b[2] <= rd_b[1];
    end
    assign mb_rdata = rd_b[2];

    // ---------------- scoreboard / reference model ----------------
    logic [31:0] ref_mem [0:2048] = '{default: 32'h0};
    logic [32:0] exp_q_a[$];
    logic [32:0] exp_q_b[$];
    int          due_q_a[$];
    int          due_q_b[$];
    logic        tb_last    = 1'b1;
    logic        err_pend   = 1'b0;
    logic [31:0] held_addr  = 32'h0;
    logic [31:0] held_wdata = 32'h0;
    logic        exp_f, exp_l, exp_men, exp_wr;
    logic [31:0] exp_addr, exp_wdata;
    logic [32:0] e;

    function automatic logic legal_addr(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (({1'b0, a} + 33'd3) < 33'd8196);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            n_cmp++;
            if ({fa_gnt, la_gnt, fb_gnt, lb_gnt, ma_en, mb_en, fa_rvalid, fb_rvalid} !== 8'b0) begin
                n_fail++;
                $display("FAIL rst_quiet: gnt/en/rvalid=%b required 00000000",
                         {fa_gnt, la_gnt, fb_gnt, lb_gnt, ma_en, mb_en, fa_rvalid, fb_rvalid});
            end
            exp_q_a.delete(); due_q_a.delete();
            exp_q_b.delete(); due_q_b.delete();
            tb_last    = 1'b1;
            err_pend   = 1'b0;
            held_addr  = 32'h0;
            held_wdata = 32'h0;
        end else begin
            exp_f   = f_req && (!l_req || tb_last);
            exp_l   = l_req && !exp_f;
            exp_wr  = exp_l && legal_addr(l_addr);
            exp_men = (exp_f && legal_addr(f_addr)) || exp_wr;
            exp_addr  = exp_men ? (exp_f ? f_addr : l_addr) : held_addr;
            exp_wdata = exp_wr ? l_wdata : held_wdata;

            n_cmp++;
            if ({fa_gnt, la_gnt, fb_gnt, lb_gnt} !== {exp_f, exp_l, exp_f, exp_l}) begin
                n_fail++;
                $display("FAIL grant @%0d: a f/l=%b%b b f/l=%b%b required %b%b", cyc,
                         fa_gnt, la_gnt, fb_gnt, lb_gnt, exp_f, exp_l);
            end
            n_cmp++;
            if ({ma_en, ma_we, mb_en, mb_we} !== {exp_men, exp_wr, exp_men, exp_wr}) begin
                n_fail++;
                $display("FAIL strobe @%0d: a en/we=%b%b b en/we=%b%b required %b%b", cyc,
                         ma_en, ma_we, mb_en, mb_we, exp_men, exp_wr);
            end
            n_cmp++;
            if ({ma_addr, ma_wdata, mb_addr, mb_wdata} !== {exp_addr, exp_wdata, exp_addr, exp_wdata}) begin
                n_fail++;
                $display("FAIL addr_data @%0d: a=%h/%h b=%h/%h required %h/%h", cyc,
                         ma_addr, ma_wdata, mb_addr, mb_wdata, exp_addr, exp_wdata);
            end
            n_cmp++;
            if ({la_err, lb_err} !== {err_pend, err_pend}) begin
                n_fail++;
                $display("FAIL l_err @%0d: a=%b b=%b required %b", cyc, la_err, lb_err, err_pend);
            end

            // response, latency 1 instance
            if (exp_q_a.size() > 0 && due_q_a[0] == cyc) begin
                e = exp_q_a.pop_front();
                void'(due_q_a.pop_front());
                n_cmp++;
                if (fa_rvalid !== 1'b1 || {fa_fault, fa_rdata} !== e) begin
                    n_fail++;
                    $display("FAIL resp_a @%0d: rvalid=%b fault=%b data=%h required 1 %b %h", cyc,
                             fa_rvalid, fa_fault, fa_rdata, e[32], e[31:0]);
                end
            end else if (fa_rvalid !== 1'b0) begin
                n_cmp++; n_fail++;
                $display("FAIL resp_a @%0d: unexpected rvalid=%b required 0", cyc, fa_rvalid);
            end
            // response, latency 3 instance
            if (exp_q_b.size() > 0 && due_q_b[0] == cyc) begin
                e = exp_q_b.pop_front();
                void'(due_q_b.pop_front());
                n_cmp++;
                if (fb_rvalid !== 1'b1 || {fb_fault, fb_rdata} !== e) begin
                    n_fail++;
                    $display("FAIL resp_b @%0d: rvalid=%b fault=%b data=%h required 1 %b %h", cyc,
                             fb_rvalid, fb_fault, fb_rdata, e[32], e[31:0]);
                end
            end else if (fb_rvalid !== 1'b0) begin
                n_cmp++; n_fail++;
                $display("FAIL resp_b @%0d: unexpected rvalid=%b required 0", cyc, fb_rvalid);
            end

            if (exp_f) begin
                e = legal_addr(f_addr) ? {1'b0, ref_mem[f_addr[13:2]]} : {1'b1, 32'h0};
                exp_q_a.push_back(e); due_q_a.push_back(cyc + 1);
                exp_q_b.push_back(e); due_q_b.push_back(cyc + 3);
                tb_last = 1'b0;
            end
            if (exp_l) tb_last = 1'b1;
            if (exp_wr) ref_mem[l_addr[13:2]] = l_wdata;
            err_pend   = exp_l && !legal_addr(l_addr);
            held_addr  = exp_addr;
            held_wdata = exp_wdata;
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; return at posedge+1 of the cycle after the grant.
    task automatic drive_fetch(input logic [31:0] a, output int gc, output logic men);
        f_req = 1'b1; f_addr = a; gc = -1; men = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (fa_gnt) begin gc = cyc; men = ma_en; break; end
        end
        if (gc < 0) begin
            n_cmp++; n_fail++;
            $display("FAIL fetch_timeout: no f_gnt for addr %h required within 20 cycles", a);
        end
        @(posedge clk); #1;
        f_req = 1'b0;
    endtask

    task automatic drive_write(input logic [31:0] a, input logic [31:0] d, output int gc, output logic men);
        l_req = 1'b1; l_addr = a; l_wdata = d; gc = -1; men = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (la_gnt) begin gc = cyc; men = ma_en; break; end
        end
        if (gc < 0) begin
            n_cmp++; n_fail++;
            $display("FAIL write_timeout: no l_gnt for addr %h required within 20 cycles", a);
        end
        @(posedge clk); #1;
        l_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 2052)) << 2;
        if ($urandom_range(0, 7) == 0) a = a | 32'd2;
        return a;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1; f_req = 1'b0; l_req = 1'b0;
        f_addr = '0; l_addr = '0; l_wdata = '0;
        idle(2);
        f_req = 1'b1; l_req = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({fa_gnt, la_gnt, fa_rvalid, fa_fault, la_err, ma_en, ma_we, fa_rdata, ma_addr, ma_wdata} !== '0 ||
            {fb_gnt, lb_gnt, fb_rvalid, fb_fault, lb_err, mb_en, mb_we, fb_rdata, mb_addr, mb_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: a gnt=%b%b en=%b addr=%h b gnt=%b%b en=%b addr=%h required all 0",
                     fa_gnt, la_gnt, ma_en, ma_addr, fb_gnt, lb_gnt, mb_en, mb_addr);
        end
        @(posedge clk); #1;
        f_req = 1'b0; l_req = 1'b0; rst = 1'b0;
        idle(1);
    endtask

    task automatic test_write_read;
        int gc; logic men;
        drive_write(32'h0, 32'h00000013, gc, men);
        n_cmp++;
        if (men !== 1'b1) begin
            n_fail++; $display("FAIL wr_strobe: m_en=%b required 1", men);
        end
        @(negedge clk);
        n_cmp++;
        if (la_gnt !== 1'b0) begin
            n_fail++; $display("FAIL wr_gnt_once: l_gnt=%b required 0", la_gnt);
        end
        @(posedge clk); #1;
        drive_fetch(32'h0, gc, men);
        @(negedge clk);
        n_cmp++;
        if ({fa_rvalid, fa_fault, fa_rdata} !== {1'b1, 1'b0, 32'h00000013}) begin
            n_fail++;
            $display("FAIL rd_after_wr: rvalid=%b fault=%b data=%h required 1 0 00000013", fa_rvalid, fa_fault, fa_rdata);
        end
        idle(5);
    endtask

    task automatic test_tie;
        int gc; logic men;
        drive_write(32'h20, 32'hA5A50001, gc, men);
        f_req = 1'b1; f_addr = 32'h10;
        l_req = 1'b1; l_addr = 32'h24; l_wdata = 32'hA5A50002;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({fa_gnt, la_gnt, ma_en, ma_we} !== {(i % 2 == 0), (i % 2 == 1), 1'b1, (i % 2 == 1)}) begin
                n_fail++;
                $display("FAIL tie_%0d: f/l/en/we=%b%b%b%b required %b%b1%b", i, fa_gnt, la_gnt, ma_en, ma_we,
                         (i % 2 == 0), (i % 2 == 1), (i % 2 == 1));
            end
            @(posedge clk); #1;
            if (i % 2 == 0) f_addr = f_addr + 32'd4;
            else begin l_addr = l_addr + 32'd4; l_wdata = l_wdata + 32'd1; end
        end
        f_req = 1'b0; l_req = 1'b0;
        idle(5);
    endtask

    task automatic test_fetch_fault;
        int gc; logic men;
        logic [31:0] addrs [0:1];
        addrs[0] = 32'h2; addrs[1] = 32'd8196;
        for (int i = 0; i < 2; i++) begin
            drive_fetch(addrs[i], gc, men);
            n_cmp++;
            if (men !== 1'b0) begin
                n_fail++; $display("FAIL fault_strobe_%0d: m_en=%b required 0", i, men);
            end
            @(negedge clk);
            n_cmp++;
            if ({fa_rvalid, fa_fault, fa_rdata} !== {1'b1, 1'b1, 32'h0}) begin
                n_fail++;
                $display("FAIL fault_resp_%0d: rvalid=%b fault=%b data=%h required 1 1 00000000", i,
                         fa_rvalid, fa_fault, fa_rdata);
            end
            @(posedge clk); #1;
        end
        idle(5);
    endtask

    task automatic test_loader_err;
        int gc; logic men;
        logic [31:0] addrs [0:1];
        addrs[0] = 32'h6; addrs[1] = 32'hFFFFFFFD;
        for (int i = 0; i < 2; i++) begin
            drive_write(addrs[i], 32'hBAD0BAD0, gc, men);
            n_cmp++;
            if (men !== 1'b0) begin
                n_fail++; $display("FAIL err_strobe_%0d: m_en=%b required 0", i, men);
            end
            @(negedge clk);
            n_cmp++;
            if ({la_err, lb_err} !== 2'b11) begin
                n_fail++; $display("FAIL err_pulse_%0d: l_err a/b=%b%b required 11", i, la_err, lb_err);
            end
            @(posedge clk); #1;
            @(negedge clk);
            n_cmp++;
            if ({la_err, lb_err} !== 2'b00) begin
                n_fail++; $display("FAIL err_width_%0d: l_err a/b=%b%b required 00", i, la_err, lb_err);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        int gc; logic men;
        logic [31:0] words [0:2];
        words[0] = 32'h00000013; words[1] = 32'h11110004; words[2] = 32'h22220008;
        drive_write(32'h4, words[1], gc, men);
        drive_write(32'h8, words[2], gc, men);
        f_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            f_addr = 32'(i * 4);
            @(negedge clk);
            n_cmp++;
            if (fb_gnt !== 1'b1) begin
                n_fail++; $display("FAIL b2b_gnt_%0d: f_gnt=%b required 1", i, fb_gnt);
            end
            @(posedge clk); #1;
        end
        f_req = 1'b0;
        // now in grant cycle + 3 of the first fetch
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({fb_rvalid, fb_fault, fb_rdata} !== {1'b1, 1'b0, words[i]}) begin
                n_fail++;
                $display("FAIL b2b_resp_%0d: rvalid=%b fault=%b data=%h required 1 0 %h", i,
                         fb_rvalid, fb_fault, fb_rdata, words[i]);
            end
        end
        idle(5);
    endtask

    task automatic test_reset_mid;
        f_req = 1'b1; f_addr = 32'h4;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (fa_gnt !== 1'b1) begin
                n_fail++; $display("FAIL mid_gnt_%0d: f_gnt=%b required 1", i, fa_gnt);
            end
            @(posedge clk); #1;
            f_addr = 32'h8;
        end
        f_req = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({fa_rvalid, fb_rvalid} !== 2'b00) begin
                n_fail++; $display("FAIL mid_flush_%0d: rvalid a/b=%b%b required 00", i, fa_rvalid, fb_rvalid);
            end
        end
        @(posedge clk); #1;
        f_req = 1'b1; f_addr = 32'hC; l_req = 1'b1; l_addr = 32'h30; l_wdata = 32'h0C0FFEE0;
        @(negedge clk);
        n_cmp++;
        if ({fa_gnt, la_gnt} !== 2'b10) begin
            n_fail++; $display("FAIL post_rst_tie: f/l=%b%b required 10", fa_gnt, la_gnt);
        end
        @(posedge clk); #1;
        f_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({fa_gnt, la_gnt} !== 2'b01) begin
            n_fail++; $display("FAIL post_rst_loader: f/l=%b%b required 01", fa_gnt, la_gnt);
        end
        @(posedge clk); #1;
        l_req = 1'b0;
        idle(5);
    endtask

    task automatic test_random;
        logic fg, lg;
        for (int i = 0; i < 300; i++) begin
            if (!f_req && $urandom_range(0, 1) == 1) begin
                f_req = 1'b1; f_addr = rand_addr();
            end
            if (!l_req && $urandom_range(0, 2) == 0) begin
                l_req = 1'b1; l_addr = rand_addr(); l_wdata = $urandom();
            end
            @(negedge clk);
            fg = fa_gnt; lg = la_gnt;
            n_cmp++;
            if (fg && lg) begin
                n_fail++; $display("FAIL rand_excl_%0d: f/l=%b%b required at most one", i, fg, lg);
            end
            @(posedge clk); #1;
            if (fg) f_req = 1'b0;
            if (lg) l_req = 1'b0;
        end
        f_req = 1'b0; l_req = 1'b0;
        idle(6);
        n_cmp++;
        if (exp_q_a.size() != 0 || exp_q_b.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending a=%0d b=%0d required 0 0", exp_q_a.size(), exp_q_b.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_tie();
        test_fetch_fault();
        test_loader_err();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
